swerv_axi_rd_arb: RTL and testbench

Round-robin arbiter that shares one downstream AXI4 read port between the three SweRV read masters: IFU (index 0), LSU (index 1) and SB debug (index 2). It sits between the core wrapper's read channels and the SoC interconnect. Each forwarded request is tagged with its master index in the upper ARID bits, and read data is routed back by that tag. Per-master outstanding-transaction counters throttle each requester.

---
 rtl/swerv_axi_arb_pkg.sv | 47 ++++
 rtl/swerv_outst_cnt.sv | 60 ++++++
 rtl/swerv_axi_rd_arb.sv | 277 +++++++++++++++++++++++++++
 tb/tb_swerv_axi_rd_arb.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/swerv_axi_arb_pkg.sv
// ---------------------------------------------------------------------------
// swerv_axi_arb_pkg
// Shared types and constants for the SweRV AXI4 read arbiter.
//   - Master index constants (IFU/LSU/SB) that double as the ARID/RID tag.
//   - TAG_ILLEGAL: the one tag value no master owns.
//   - ar_payload_t: one captured AR request. The id field is sized for the
//     widest supported tagged ID (ID_W + 2 <= AR_ID_MAX_W); unused upper
//     bits are kept at zero.
//   - slot_state_e: state of the one-entry AR output register.
//   - mst_next(): round-robin successor of a master index (modulo 3).
// ---------------------------------------------------------------------------
package swerv_axi_arb_pkg;

    localparam int unsigned NUM_MST     = 3;
    localparam int unsigned AR_ID_MAX_W = 16;

    localparam logic [1:0] MST_IFU     = 2'd0;
    localparam logic [1:0] MST_LSU     = 2'd1;
    localparam logic [1:0] MST_SB      = 2'd2;
    localparam logic [1:0] TAG_ILLEGAL = 2'd3;

    typedef enum logic [0:0] {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_e;

    typedef struct packed {
        logic [AR_ID_MAX_W-1:0] id;
        logic [31:0]            addr;
        logic [7:0]             len;
        logic [2:0]             size;
        logic [1:0]             burst;
    } ar_payload_t;

    // Next master in round-robin order; wraps SB back to IFU.
    function automatic logic [1:0] mst_next(input logic [1:0] idx);
        logic [1:0] nxt;
        case (idx)
            MST_IFU: nxt = MST_LSU;
            MST_LSU: nxt = MST_SB;
            MST_SB:  nxt = MST_IFU;
            default: nxt = MST_IFU;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/swerv_outst_cnt.sv
// ---------------------------------------------------------------------------
// swerv_outst_cnt
// Per-master outstanding-burst counter, clog2(MAX_OUTST)+1 bits wide so that
// the value MAX_OUTST itself is representable.
// Ports:
//   clk, rst  - clock, synchronous active-high reset
//   inc_i     - a burst was granted to this master
//   dec_i     - a last beat for this master was accepted
//   full_o    - counter has reached MAX_OUTST (master must not be granted)
//   nz_o      - at least one burst outstanding
// A decrement at zero is ignored (stray rlast). Simultaneous increment and
// valid decrement leave the count unchanged.
// ---------------------------------------------------------------------------
module swerv_outst_cnt #(
    parameter int unsigned MAX_OUTST = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic inc_i,
    input  logic dec_i,
    output logic full_o,
    output logic nz_o
);

    localparam int unsigned   CW    = $clog2(MAX_OUTST) + 1;
    localparam logic [CW-1:0] ONE   = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0] ZERO  = {CW{1'b0}};
    localparam logic [CW-1:0] MAX_C = CW'(MAX_OUTST);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          dec_ok_s;

    assign dec_ok_s = dec_i && (cnt_q != ZERO);

    // Next count: up on grant, down on accepted rlast, hold when both.
    always_comb begin
        cnt_d = cnt_q;
        if (inc_i && !dec_ok_s && (cnt_q != MAX_C)) begin
            cnt_d = cnt_q + ONE;
        end else if (dec_ok_s && !inc_i) begin
            cnt_d = cnt_q - ONE;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= ZERO;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign full_o = (cnt_q == MAX_C);
    assign nz_o   = (cnt_q != ZERO);

endmodule

// File: rtl/swerv_axi_rd_arb.sv
// ---------------------------------------------------------------------------
// swerv_axi_rd_arb
// Shares one downstream AXI4 read port between the IFU (0), LSU (1) and
// SB debug (2) read masters.
// AR side: round-robin grant (combinational s_arready) into a one-entry
//   output register; the forwarded ARID is {master index, upstream ARID}.
// R side: combinational routing by the RID tag; tag 2'b11 is illegal, the
//   beat is swallowed (m_rready forced high) and rid_err pulses one cycle
//   later.
// Per-master outstanding counters stop a master at MAX_OUTST bursts.
// Ports:
//   clk, rst                        - clock, synchronous active-high reset
//   s_ar* (packed x3), s_arready    - upstream AR channels, per master
//   s_rvalid/s_rready (x3), s_r*    - upstream R channel, shared payload
//   m_ar*, m_r*                     - downstream AXI4 read port
//   outst_any                       - any master has a burst in flight
//   rid_err                         - pulse after a beat with illegal tag
// Configuration macro: RV_AXI_RD_ARB_IFU_PRIO_EN
//   defined   - IFU wins whenever eligible; LSU/SB round-robin, and the
//               pointer moves only on their grants.
//   undefined - plain 3-way round-robin.
// ---------------------------------------------------------------------------
module swerv_axi_rd_arb
    import swerv_axi_arb_pkg::*;
#(
    parameter int unsigned ID_W      = 4,
    parameter int unsigned MAX_OUTST = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [2:0]        s_arvalid,
    output logic [2:0]        s_arready,
    input  logic [3*ID_W-1:0] s_arid,
    input  logic [3*32-1:0]   s_araddr,
    input  logic [3*8-1:0]    s_arlen,
    input  logic [3*3-1:0]    s_arsize,
    input  logic [3*2-1:0]    s_arburst,
    output logic [2:0]        s_rvalid,
    input  logic [2:0]        s_rready,
    output logic [ID_W-1:0]   s_rid,
    output logic [63:0]       s_rdata,
    output logic [1:0]        s_rresp,
    output logic              s_rlast,
    output logic              m_arvalid,
    input  logic              m_arready,
    output logic [ID_W+1:0]   m_arid,
    output logic [31:0]       m_araddr,
    output logic [7:0]        m_arlen,
    output logic [2:0]        m_arsize,
    output logic [1:0]        m_arburst,
    input  logic              m_rvalid,
    output logic              m_rready,
    input  logic [ID_W+1:0]   m_rid,
    input  logic [63:0]       m_rdata,
    input  logic [1:0]        m_rresp,
    input  logic              m_rlast,
    output logic              outst_any,
    output logic              rid_err
);

    slot_state_e state_q, state_d;
    ar_payload_t slot_q, slot_d;
    logic [1:0]  rr_ptr_q, rr_ptr_d;
    logic        rid_err_q, rid_err_d;

    ar_payload_t req_pl_s [NUM_MST];
    ar_payload_t win_pl_s;
    logic [3:0]  elig_s;       // bit 3 is a constant-0 pad so a 2-bit index never overruns
    logic [3:0]  rr_elig_s;
    logic [2:0]  full_s;
    logic [2:0]  nz_s;
    logic [2:0]  inc_s;
    logic [2:0]  dec_s;
    logic [1:0]  win_idx_s;
    logic [1:0]  cand_s;
    logic [1:0]  sel_s;
    logic        win_vld_s;
    logic        loadable_s;
    logic        grant_s;
    logic        r_last_hs_s;
    logic        unused_id_s;

    // Unpack each master's AR request and attach its tag.
    always_comb begin
        for (int i = 0; i < NUM_MST; i++) begin
            req_pl_s[i]                 = '0;
            req_pl_s[i].id[ID_W+1:0]    = {2'(i), s_arid[i*ID_W +: ID_W]};
            req_pl_s[i].addr            = s_araddr[i*32 +: 32];
            req_pl_s[i].len             = s_arlen[i*8 +: 8];
            req_pl_s[i].size            = s_arsize[i*3 +: 3];
            req_pl_s[i].burst           = s_arburst[i*2 +: 2];
        end
    end

    assign elig_s = {1'b0, s_arvalid & ~full_s};

`ifdef RV_AXI_RD_ARB_IFU_PRIO_EN
    // IFU is handled by fixed priority, so it never joins the rotation.
    assign rr_elig_s = elig_s & 4'b0110;
`else
    assign rr_elig_s = elig_s;
`endif

    // Winner search: first eligible master at or after rr_ptr, modulo 3.
    always_comb begin
        win_vld_s = 1'b0;
        win_idx_s = MST_IFU;
        cand_s    = rr_ptr_q;
        for (int k = 0; k < NUM_MST; k++) begin
            if (!win_vld_s && rr_elig_s[cand_s]) begin
                win_vld_s = 1'b1;
                win_idx_s = cand_s;
            end else begin
                win_vld_s = win_vld_s;
            end
            cand_s = mst_next(cand_s);
        end
`ifdef RV_AXI_RD_ARB_IFU_PRIO_EN
        if (elig_s[0]) begin
            win_vld_s = 1'b1;
            win_idx_s = MST_IFU;
        end else begin
            win_vld_s = win_vld_s;
        end
`endif
    end

    // Reset is folded in so no grant is ever signalled while in reset.
    assign loadable_s = !rst && ((state_q == SLOT_EMPTY) || m_arready);
    assign grant_s    = loadable_s && win_vld_s;

    // One-hot grant and winner payload select.
    always_comb begin
        s_arready = 3'b000;
        win_pl_s  = req_pl_s[0];
        case (win_idx_s)
            MST_IFU: win_pl_s = req_pl_s[0];
            MST_LSU: win_pl_s = req_pl_s[1];
            MST_SB:  win_pl_s = req_pl_s[2];
            default: win_pl_s = req_pl_s[0];
        endcase
        if (grant_s) begin
            case (win_idx_s)
                MST_IFU: s_arready = 3'b001;
                MST_LSU: s_arready = 3'b010;
                MST_SB:  s_arready = 3'b100;
                default: s_arready = 3'b000;
            endcase
        end else begin
            s_arready = 3'b000;
        end
    end

    assign inc_s = s_arready;

    // Slot FSM next state, payload capture and round-robin pointer update.
    always_comb begin
        state_d  = state_q;
        slot_d   = slot_q;
        rr_ptr_d = rr_ptr_q;
        case (state_q)
            SLOT_EMPTY: begin
                if (grant_s) begin
                    state_d = SLOT_FULL;
                    slot_d  = win_pl_s;
                end else begin
                    state_d = SLOT_EMPTY;
                end
            end
            SLOT_FULL: begin
                // A grant here implies m_arready: back-to-back reload.
                if (grant_s) begin
                    state_d = SLOT_FULL;
                    slot_d  = win_pl_s;
                end else if (m_arready) begin
                    state_d = SLOT_EMPTY;
                end else begin
                    state_d = SLOT_FULL;
                end
            end
            default: begin
                state_d = SLOT_EMPTY;
            end
        endcase
`ifdef RV_AXI_RD_ARB_IFU_PRIO_EN
        if (grant_s && (win_idx_s != MST_IFU)) begin
            rr_ptr_d = mst_next(win_idx_s);
        end else begin
            rr_ptr_d = rr_ptr_q;
        end
`else
        if (grant_s) begin
            rr_ptr_d = mst_next(win_idx_s);
        end else begin
            rr_ptr_d = rr_ptr_q;
        end
`endif
    end

    // Slot, pointer and error-pulse registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= SLOT_EMPTY;
            slot_q    <= '0;
            rr_ptr_q  <= MST_IFU;
            rid_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            slot_q    <= slot_d;
            rr_ptr_q  <= rr_ptr_d;
            rid_err_q <= rid_err_d;
        end
    end

    assign m_arvalid   = (state_q == SLOT_FULL);
    assign m_arid      = slot_q.id[ID_W+1:0];
    assign m_araddr    = slot_q.addr;
    assign m_arlen     = slot_q.len;
    assign m_arsize    = slot_q.size;
    assign m_arburst   = slot_q.burst;
    assign unused_id_s = ^slot_q.id[AR_ID_MAX_W-1:ID_W+2];

    assign sel_s       = m_rid[ID_W+1:ID_W];
    assign r_last_hs_s = m_rvalid && m_rready && m_rlast;

    // R routing by tag; the illegal tag is swallowed and flagged.
    always_comb begin
        s_rvalid  = 3'b000;
        m_rready  = 1'b1;
        dec_s     = 3'b000;
        rid_err_d = 1'b0;
        case (sel_s)
            MST_IFU: begin
                s_rvalid = {2'b00, m_rvalid};
                m_rready = s_rready[0];
                dec_s    = {2'b00, r_last_hs_s};
            end
            MST_LSU: begin
                s_rvalid = {1'b0, m_rvalid, 1'b0};
                m_rready = s_rready[1];
                dec_s    = {1'b0, r_last_hs_s, 1'b0};
            end
            MST_SB: begin
                s_rvalid = {m_rvalid, 2'b00};
                m_rready = s_rready[2];
                dec_s    = {r_last_hs_s, 2'b00};
            end
            default: begin
                s_rvalid  = 3'b000;
                m_rready  = 1'b1;
                rid_err_d = m_rvalid;
            end
        endcase
    end

    assign s_rid   = m_rid[ID_W-1:0];
    assign s_rdata = m_rdata;
    assign s_rresp = m_rresp;
    assign s_rlast = m_rlast;

    for (genvar g = 0; g < NUM_MST; g++) begin : g_cnt
        swerv_outst_cnt #(
            .MAX_OUTST (MAX_OUTST)
        ) u_cnt (
            .clk    (clk),
            .rst    (rst),
            .inc_i  (inc_s[g]),
            .dec_i  (dec_s[g]),
            .full_o (full_s[g]),
            .nz_o   (nz_s[g])
        );
    end

    assign outst_any = |nz_s;
    assign rid_err   = rid_err_q;

endmodule

// File: tb/tb_swerv_axi_rd_arb.sv
// ---------------------------------------------------------------------------
// tb_swerv_axi_rd_arb
// Directed bench for swerv_axi_rd_arb. Expected AR transfers and R beats are
// queued as stimulus is issued; a negedge monitor pops and compares whenever
// the DUT completes a downstream AR or upstream R handshake.
// Honours RV_AXI_RD_ARB_IFU_PRIO_EN for the arbitration-order test.
// ---------------------------------------------------------------------------
module tb_swerv_axi_rd_arb;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  s_arvalid = 3'b111;
    logic [2:0]  s_arready;
    logic [11:0] s_arid    = {4'hA, 4'h2, 4'h5};
    logic [95:0] s_araddr  = {32'h2000_0040, 32'h0000_1000, 32'h0000_0100};
    logic [23:0] s_arlen   = {8'h00, 8'h03, 8'h07};
    logic [8:0]  s_arsize  = {3'd3, 3'd3, 3'd3};
    logic [5:0]  s_arburst = {2'b01, 2'b01, 2'b01};
    logic [2:0]  s_rvalid;
    logic [2:0]  s_rready = 3'b111;
    logic [3:0]  s_rid;
    logic [63:0] s_rdata;
    logic [1:0]  s_rresp;
    logic        s_rlast;
    logic        m_arvalid;
    logic        m_arready = 1'b0;
    logic [5:0]  m_arid;
    logic [31:0] m_araddr;
    logic [7:0]  m_arlen;
    logic [2:0]  m_arsize;
    logic [1:0]  m_arburst;
    logic        m_rvalid = 1'b0;
    logic        m_rready;
    logic [5:0]  m_rid    = 6'd0;
    logic [63:0] m_rdata  = 64'd0;
    logic [1:0]  m_rresp  = 2'd0;
    logic        m_rlast  = 1'b0;
    logic        outst_any;
    logic        rid_err;

    int n_checks = 0;
    int n_pass   = 0;
    logic [50:0] ar_q [$];
    logic [72:0] r_q  [$];
    logic [1:0]  mon_idx;

    swerv_axi_rd_arb #(.ID_W(4), .MAX_OUTST(8)) dut (
        .clk(clk), .rst(rst),
        .s_arvalid(s_arvalid), .s_arready(s_arready), .s_arid(s_arid),
        .s_araddr(s_araddr), .s_arlen(s_arlen), .s_arsize(s_arsize),
        .s_arburst(s_arburst), .s_rvalid(s_rvalid), .s_rready(s_rready),
        .s_rid(s_rid), .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rlast(s_rlast),
        .m_arvalid(m_arvalid), .m_arready(m_arready), .m_arid(m_arid),
        .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arsize(m_arsize),
        .m_arburst(m_arburst), .m_rvalid(m_rvalid), .m_rready(m_rready),
        .m_rid(m_rid), .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rlast(m_rlast),
        .outst_any(outst_any), .rid_err(rid_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Hand-written downstream AR image {m_arid, addr, len, size, burst} per master.
    function automatic logic [50:0] exp_ar(input int idx);
        case (idx)
            0:       return {6'b00_0101, 32'h0000_0100, 8'h07, 3'd3, 2'b01};
            1:       return {6'b01_0010, 32'h0000_1000, 8'h03, 3'd3, 2'b01};
            default: return {6'b10_1010, 32'h2000_0040, 8'h00, 3'd3, 2'b01};
        endcase
    endfunction

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_grant(input string name, input logic [2:0] exp_gnt, input int idx);
        #1;
        check(name, s_arready, exp_gnt);
        if (exp_gnt != 3'b000) ar_q.push_back(exp_ar(idx));
    endtask

    task automatic r_beat(input logic [1:0] tag, input logic [3:0] rid,
                          input logic [63:0] data, input logic last);
        m_rvalid = 1'b1;
        m_rid    = {tag, rid};
        m_rdata  = data;
        m_rresp  = tag ^ 2'b01;
        m_rlast  = last;
        if (tag != 2'b11) r_q.push_back({tag, rid, tag ^ 2'b01, data, last});
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
    endtask

    // Monitor: compare every completed AR and R handshake with the queues.
    always @(negedge clk) begin
        if (!rst) begin
            if (m_arvalid && m_arready) begin
                if (ar_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL ar_unexpected: got m_arid 0x%0h, required no transfer", m_arid);
                end else begin
                    check("ar_payload", {m_arid, m_araddr, m_arlen, m_arsize, m_arburst},
                          ar_q.pop_front());
                end
            end
            if (|(s_rvalid & s_rready)) begin
                mon_idx = 2'd0;
                for (int i = 0; i < 3; i++) if (s_rvalid[i]) mon_idx = 2'(i);
                check("r_onehot", $onehot(s_rvalid), 1'b1);
                if (r_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL r_unexpected: got s_rvalid %b, required none", s_rvalid);
                end else begin
                    check("r_beat", {mon_idx, s_rid, s_rresp, s_rdata, s_rlast}, r_q.pop_front());
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time exceeded, required completion");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset state, with all masters requesting.
        repeat (2) cycle();
        check("rst_s_arready", s_arready, 3'b000);
        check("rst_m_arvalid", m_arvalid, 1'b0);
        check("rst_outst_any", outst_any, 1'b0);
        check("rst_rid_err",   rid_err,   1'b0);
        s_arvalid = 3'b000;
        rst = 1'b0;

        // LSU single AR, held while m_arready low, then a 4-beat burst back.
        s_arvalid = 3'b010;
        expect_grant("t1_gnt_lsu", 3'b010, 1);
        cycle();
        s_arvalid = 3'b000;
        check("t1_m_arvalid", m_arvalid, 1'b1);
        check("t1_m_arid",    m_arid,    6'b01_0010);
        check("t1_m_araddr",  m_araddr,  32'h0000_1000);
        check("t1_outst_any", outst_any, 1'b1);
        cycle();
        check("t1_hold", {m_arvalid, m_araddr}, {1'b1, 32'h0000_1000});
        m_arready = 1'b1;
        cycle();
        check("t1_slot_empty", m_arvalid, 1'b0);
        m_rvalid = 1'b1;
        m_rid    = 6'b01_0010;
        s_rready = 3'b101;
        #1;
        check("t1_r_stall_ready", m_rready, 1'b0);
        check("t1_r_route",       s_rvalid, 3'b010);
        s_rready = 3'b111;
        for (int b = 0; b < 4; b++) begin
            r_beat(2'd1, 4'h2, 64'hA5A5_0000_0000_0000 + 64'(b), b == 3);
            cycle();
            if (b == 2) check("t1_outst_mid", outst_any, 1'b1);
        end
        m_rvalid = 1'b0;
        m_rlast  = 1'b0;
        #1;
        check("t1_outst_done", outst_any, 1'b0);

        // All masters requesting, m_arready high.
        pulse_reset();
        s_arvalid = 3'b111;
`ifdef RV_AXI_RD_ARB_IFU_PRIO_EN
        for (int k = 0; k < 6; k++) begin
            expect_grant($sformatf("t2_ifu_prio%0d", k), 3'b001, 0);
            cycle();
        end
        s_arvalid = 3'b110;
        expect_grant("t2_lsu_after_ifu", 3'b010, 1);
        cycle();
        expect_grant("t2_sb_after_lsu", 3'b100, 2);
        cycle();
`else
        for (int k = 0; k < 6; k++) begin
            expect_grant($sformatf("t2_rr%0d", k), 3'b001 << (k % 3), k % 3);
            cycle();
        end
`endif
        s_arvalid = 3'b000;
        cycle();

        // LSU saturation at 8 outstanding, SB still served, release by rlast.
        pulse_reset();
        s_arvalid = 3'b010;
        for (int k = 0; k < 8; k++) begin
            expect_grant($sformatf("t4_lsu%0d", k), 3'b010, 1);
            cycle();
        end
        expect_grant("t4_lsu_sat", 3'b000, 1);
        cycle();
        s_arvalid = 3'b110;
        expect_grant("t4_sb_served", 3'b100, 2);
        cycle();
        s_arvalid = 3'b010;
        r_beat(2'd1, 4'h2, 64'h0000_0000_DEAD_BEEF, 1'b1);
        expect_grant("t4_lsu_still_sat", 3'b000, 1);
        cycle();
        m_rvalid = 1'b0;
        m_rlast  = 1'b0;
        expect_grant("t4_lsu_regrant", 3'b010, 1);
        cycle();
        s_arvalid = 3'b000;
        cycle();

        // Illegal tag: swallowed, flagged once, counters untouched.
        s_rready = 3'b000;
        r_beat(2'b11, 4'h7, 64'h1234_5678_9ABC_DEF0, 1'b1);
        #1;
        check("t5_m_rready", m_rready, 1'b1);
        check("t5_s_rvalid", s_rvalid, 3'b000);
        check("t5_rid_err_pre", rid_err, 1'b0);
        cycle();
        m_rvalid = 1'b0;
        m_rlast  = 1'b0;
        check("t5_rid_err_pulse", rid_err, 1'b1);
        cycle();
        check("t5_rid_err_clear", rid_err, 1'b0);
        s_arvalid = 3'b010;
        expect_grant("t5_lsu_still_sat", 3'b000, 1);
        check("t5_outst_any", outst_any, 1'b1);
        s_arvalid = 3'b000;
        s_rready  = 3'b111;
        cycle();

        // Grant and rlast to IFU in the same cycle at cnt=3; underflow guard.
        pulse_reset();
        s_arvalid = 3'b001;
        for (int k = 0; k < 3; k++) begin
            expect_grant($sformatf("t6_ifu%0d", k), 3'b001, 0);
            cycle();
        end
        r_beat(2'd0, 4'h5, 64'h0000_0000_0000_1111, 1'b1);
        expect_grant("t6_ifu_with_rlast", 3'b001, 0);
        cycle();
        m_rvalid  = 1'b0;
        s_arvalid = 3'b000;
        for (int k = 0; k < 3; k++) begin
            r_beat(2'd0, 4'h5, 64'h0000_0000_0000_2220 + 64'(k), 1'b1);
            cycle();
            m_rvalid = 1'b0;
            #1;
            check($sformatf("t6_outst%0d", k), outst_any, k < 2);
        end
        r_beat(2'd0, 4'h5, 64'h0000_0000_0000_3333, 1'b1);
        cycle();
        m_rvalid = 1'b0;
        #1;
        check("t6_no_underflow", outst_any, 1'b0);
        s_arvalid = 3'b001;
        expect_grant("t6_ifu_again", 3'b001, 0);
        cycle();
        s_arvalid = 3'b000;
        check("t6_outst_one", outst_any, 1'b1);
        r_beat(2'd0, 4'h5, 64'h0000_0000_0000_4444, 1'b1);
        cycle();
        m_rvalid = 1'b0;
        m_rlast  = 1'b0;
        #1;
        check("t6_outst_zero", outst_any, 1'b0);

        // Reset while the slot is FULL.
        m_arready = 1'b0;
        s_arvalid = 3'b010;
        #1;
        check("t7_gnt", s_arready, 3'b010);
        cycle();
        s_arvalid = 3'b000;
        check("t7_full", m_arvalid, 1'b1);
        rst = 1'b1;
        cycle();
        check("t7_rst_m_arvalid", m_arvalid, 1'b0);
        check("t7_rst_outst", outst_any, 1'b0);
        rst = 1'b0;
        m_arready = 1'b1;
        cycle();
        check("t7_post_rst", m_arvalid, 1'b0);

        cycle();
        check("end_ar_q", ar_q.size(), 0);
        check("end_r_q", r_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
